rr_arbiter_8: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters.
//   - Winner index is registered as a 3-bit id.
//   - The one-hot grant vector is produced by a decoder_3_to_8 instance on that id.
//   - A requester keeps the resource while its request stays high.
//   - An optional hold limit revokes the grant from a requester when others are waiting.

---
 rtl/rr_arbiter_8.sv | 100 ++++++++++
 tb/tb_rr_arbiter_8.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with an optional hold limit.
// The registered winner id drives a 3-to-8 decoder to form the one-hot grant.

module decoder_3_to_8 (
  input  logic [2:0] sel,
  output logic [7:0] dout
);
  assign dout = 8'b1 << sel;
endmodule

module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);
  localparam int HW   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0] HOLD_LAST = LAST[HW-1:0];

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      ptr, ptr_nxt, gnt_id_nxt, win;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            preempt_nxt;
  logic [7:0]      dec;
  logic            others, limit_hit, release_gnt;

  decoder_3_to_8 u_dec (.sel(gnt_id), .dout(dec));

  assign gnt_valid   = (state == GRANT);
  assign gnt         = dec & {8{gnt_valid}};
  assign others      = |(req & ~gnt);
  assign release_gnt = ~req[gnt_id];
  assign limit_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others;

  // Scan from ptr+7 down to ptr so the last hit is the closest to ptr.
  always_comb begin
    win = '0;
    for (int i = 7; i >= 0; i--)
      if (req[ptr + 3'(i)]) win = ptr + 3'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_id   <= gnt_id_nxt;
      hold_cnt <= hold_nxt;
      preempt  <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (release_gnt || limit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt     = ptr;
    gnt_id_nxt  = gnt_id;
    hold_nxt    = hold_cnt;
    preempt_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_id_nxt = win;
          hold_nxt   = '0;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          ptr_nxt = gnt_id + 3'd1;
        end else if (limit_hit) begin
          ptr_nxt     = gnt_id + 3'd1;
          preempt_nxt = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with a per-cycle one-hot and hold-limit monitor.

module tb_rr_arbiter_8;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int n_chk  = 0;
  int n_pass = 0;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Grant must be one-hot on gnt_id, and must end right after a cycle where it
  // had lasted MH cycles with someone else waiting.
  int   run = 0;
  logic must_end = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      run      = 0;
      must_end = 1'b0;
    end else begin
      if (must_end) chk("hold_limit", {31'd0, gnt_valid}, 32'd0);
      chk("onehot", {24'd0, gnt}, gnt_valid ? (32'd1 << gnt_id) : 32'd0);
      run      = gnt_valid ? run + 1 : 0;
      must_end = gnt_valid && (run >= MH) && ((req & ~gnt) != 8'h00);
    end
  end

  initial begin
    #2;
    chk("rst_gnt", {24'd0, gnt}, 32'd0);
    chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("rst_id", {29'd0, gnt_id}, 32'd0);
    chk("rst_preempt", {31'd0, preempt}, 32'd0);

    // 1. grant and release
    do_reset();
    req = 8'b0000_0100;
    step();
    chk("t1_gnt", {24'd0, gnt}, 32'h04);
    chk("t1_id", {29'd0, gnt_id}, 32'd2);
    step();
    chk("t1_gnt2", {24'd0, gnt}, 32'h04);
    req = 8'h00;
    step();
    chk("t1_rel_gnt", {24'd0, gnt}, 32'd0);
    chk("t1_rel_valid", {31'd0, gnt_valid}, 32'd0);
    chk("t1_id_hold", {29'd0, gnt_id}, 32'd2);
    chk("t1_preempt", {31'd0, preempt}, 32'd0);

    // 2. rotation with wrap, 4 cycles each, idle + preempt between grants
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < MH; c++) begin
        step();
        chk("t2_valid", {31'd0, gnt_valid}, 32'd1);
        chk("t2_id", {29'd0, gnt_id}, g % 8);
        chk("t2_nopre", {31'd0, preempt}, 32'd0);
      end
      step();
      chk("t2_idle", {24'd0, gnt}, 32'd0);
      chk("t2_preempt", {31'd0, preempt}, 32'd1);
    end

    // 3. priority pointer after releasing id 4
    do_reset();
    req = 8'b0001_0000;
    step();
    chk("t3_id4", {29'd0, gnt_id}, 32'd4);
    req = 8'h00;
    step();
    chk("t3_idle", {31'd0, gnt_valid}, 32'd0);
    req = 8'b0001_0001;
    step();
    chk("t3_first", {29'd0, gnt_id}, 32'd0);
    chk("t3_first_gnt", {24'd0, gnt}, 32'h01);
    step();
    req = 8'b0001_0000;
    step();
    chk("t3_turn", {31'd0, gnt_valid}, 32'd0);
    step();
    chk("t3_second", {29'd0, gnt_id}, 32'd4);
    chk("t3_second_gnt", {24'd0, gnt}, 32'h10);

    // 4. lone holder is never revoked
    do_reset();
    req = 8'b1000_0000;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t4_gnt", {24'd0, gnt}, 32'h80);
      chk("t4_nopre", {31'd0, preempt}, 32'd0);
    end

    // 5. asynchronous reset mid-grant
    do_reset();
    req = 8'b0100_0000;
    step();
    chk("t5_id6", {29'd0, gnt_id}, 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_gnt", {24'd0, gnt}, 32'd0);
    chk("t5_async_valid", {31'd0, gnt_valid}, 32'd0);
    chk("t5_async_id", {29'd0, gnt_id}, 32'd0);
    rst = 1'b0;
    req = 8'hC0;
    step();
    chk("t5_restart", {29'd0, gnt_id}, 32'd6);
    chk("t5_restart_v", {31'd0, gnt_valid}, 32'd1);

    // 6. random traffic; requests persist a few cycles to exercise the limit
    do_reset();
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom);
      step();
    end
    req = 8'h00;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
